// File: rtl/systolic_if.sv
// Host-side handshake, operand fetch and array feed bundle for the systolic controller.
// master = host/memory side, slave = controller side.
interface systolic_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int KW     = 8
);
  logic                  start;
  logic [KW-1:0]         k_len;
  logic                  busy;
  logic                  done;
  logic                  res_valid;
  logic                  rd_en;
  logic [KW-1:0]         rd_k;
  logic [N*DATA_W-1:0]   rd_a;
  logic [N*DATA_W-1:0]   rd_b;
  logic                  arr_clr;
  logic [N*DATA_W-1:0]   row_out;
  logic [N*DATA_W-1:0]   col_out;

  modport master (
    output start, k_len, rd_a, rd_b,
    input  busy, done, res_valid, rd_en, rd_k, arr_clr, row_out, col_out
  );

  modport slave (
    input  start, k_len, rd_a, rd_b,
    output busy, done, res_valid, rd_en, rd_k, arr_clr, row_out, col_out
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N output-stationary systolic array: clears the array,
// fetches K operand columns/rows and feeds them through per-lane skew lines.
module systolic_ctrl #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int KW     = 8
) (
  input  logic       clk,
  input  logic       rst,
  systolic_if.slave  bus
);
  // Flush counter must reach 2N-1 without overflow.
  localparam int FW = $clog2(2 * N + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

  state_t        state_reg, state_next;
  logic [KW-1:0] k_len_reg, k_len_next;
  logic [KW-1:0] k_cnt_reg, k_cnt_next;
  logic [FW-1:0] fl_cnt_reg, fl_cnt_next;
  logic          res_valid_reg, res_valid_next;
  logic          dv_reg;

  logic          done_c;
  logic          arr_clr_c;
  logic          rd_en_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      k_len_reg     <= '0;
      k_cnt_reg     <= '0;
      fl_cnt_reg    <= '0;
      res_valid_reg <= 1'b0;
      dv_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_len_reg     <= k_len_next;
      k_cnt_reg     <= k_cnt_next;
      fl_cnt_reg    <= fl_cnt_next;
      res_valid_reg <= res_valid_next;
      dv_reg        <= rd_en_c;
    end
  end

  always_comb begin
    state_next     = state_reg;
    k_len_next     = k_len_reg;
    k_cnt_next     = k_cnt_reg;
    fl_cnt_next    = fl_cnt_reg;
    res_valid_next = res_valid_reg;
    done_c         = 1'b0;
    arr_clr_c      = 1'b0;
    rd_en_c        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          k_len_next     = bus.k_len;
          res_valid_next = 1'b0;
          state_next     = CLEAR;
        end
      end
      CLEAR: begin
        arr_clr_c  = 1'b1;
        state_next = (k_len_reg == '0) ? DONE : FEED;
      end
      FEED: begin
        rd_en_c = 1'b1;
        // Compare against K-1 so K = 2^KW-1 finishes without the index wrapping.
        if (k_cnt_reg == k_len_reg - KW'(1)) begin
          k_cnt_next = '0;
          state_next = FLUSH;
        end else begin
          k_cnt_next = k_cnt_reg + KW'(1);
        end
      end
      FLUSH: begin
        if (fl_cnt_reg == FW'(2 * N - 1)) begin
          fl_cnt_next = '0;
          state_next  = DONE;
        end else begin
          fl_cnt_next = fl_cnt_reg + FW'(1);
        end
      end
      DONE: begin
        done_c         = 1'b1;
        res_valid_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = done_c;
  assign bus.arr_clr   = arr_clr_c;
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_k      = k_cnt_reg;
  assign bus.res_valid = res_valid_reg;

  logic [N*DATA_W-1:0] row_vec;
  logic [N*DATA_W-1:0] col_vec;

  // Lane gi carries gi+1 registers: one capture stage plus gi skew stages.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_W-1:0] a_pipe_reg [gi+1];
      logic [DATA_W-1:0] b_pipe_reg [gi+1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d <= gi; d++) begin
            a_pipe_reg[d] <= '0;
            b_pipe_reg[d] <= '0;
          end
        end else begin
          a_pipe_reg[0] <= dv_reg ? bus.rd_a[gi*DATA_W +: DATA_W] : '0;
          b_pipe_reg[0] <= dv_reg ? bus.rd_b[gi*DATA_W +: DATA_W] : '0;
          for (int d = 1; d <= gi; d++) begin
            a_pipe_reg[d] <= a_pipe_reg[d-1];
            b_pipe_reg[d] <= b_pipe_reg[d-1];
          end
        end
      end

      assign row_vec[gi*DATA_W +: DATA_W] = a_pipe_reg[gi];
      assign col_vec[gi*DATA_W +: DATA_W] = b_pipe_reg[gi];
    end
  endgenerate

  assign bus.row_out = row_vec;
  assign bus.col_out = col_vec;
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default 4: array dimension, N x N processing elements.
REQ-002 Parameter DATA_W, default 8: signed operand width.
REQ-003 Parameter KW, default 8: width of the inner-dimension length and index.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle job request, honoured only in IDLE.
REQ-007 k_len  in  KW  number of inner-product terms K, sampled when start is accepted.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when a job completes.
REQ-010 res_valid  out  1  array accumulators hold a complete result.
REQ-011 rd_en  out  1  operand fetch request.
REQ-012 rd_k  out  KW  inner index k of the fetched A column and B row.
REQ-013 rd_a  in  N*DATA_W  A[0..N-1][k]; lane i is bits [i*DATA_W +: DATA_W]; valid exactly 1 cycle after rd_en.
REQ-014 rd_b  in  N*DATA_W  B[k][0..N-1], using the same lane packing and timing as rd_a.
REQ-015 arr_clr  out  1  synchronous clear of all array accumulators and pipeline registers.
REQ-016 row_out  out  N*DATA_W  skewed row feed; lane i drives row i of the array.
REQ-017 col_out  out  N*DATA_W  skewed column feed; lane j drives column j of the array.

Function
REQ-018 The FSM shall have exactly the states IDLE, CLEAR, FEED, FLUSH and DONE.
REQ-019 IDLE -> CLEAR on start; start shall be ignored in every other state.
REQ-020 CLEAR shall last 1 cycle with arr_clr=1; it goes to FEED if K>0 and to DONE if K=0.
REQ-021 FEED shall last K cycles, asserting rd_en=1 with rd_k=0,1,...,K-1 on consecutive cycles; it then goes to FLUSH.
REQ-022 FLUSH shall last exactly 2N cycles, with rd_en=0, and then go to DONE.
REQ-023 DONE shall last 1 cycle with done=1 and then go to IDLE.
REQ-024 res_valid shall set on the cycle after DONE and clear when start is accepted; it is never high while busy=1.
REQ-025 A 1-bit data-valid flag shall be rd_en delayed by 1 cycle; when the flag is 0, the skew-line inputs shall be forced to zero.
REQ-026 Lane i of row_out and of col_out shall equal the captured rd_a/rd_b lane i delayed by i additional register stages; lane 0 has zero extra delay.
REQ-027 Operand k shall therefore appear on row_out/col_out lane i exactly 2+i cycles after the rd_en carrying rd_k=k.
REQ-028 All skew registers shall be zero-filled, so the array sees only zeros outside the valid window.
REQ-029 Skew registers shall shift every cycle in all states; arr_clr has no effect on them.
REQ-030 Operands shall pass through bit-exact; the block performs no arithmetic.
REQ-031 The K and index counters shall be KW bits; K = 2^KW-1 shall complete without wrap-around.
REQ-032 The FLUSH counter shall be sized to hold 2N.

Reset
REQ-033 While rst=1, all of the following shall be forced immediately, independent of clk: state=IDLE, busy=0, done=0, res_valid=0, rd_en=0, rd_k=0, arr_clr=0, data-valid flag=0, every skew register=0, and every counter=0.
REQ-034 Reset asserted mid-job shall abandon the job; after release the block shall accept a new start on the first clock edge.

Verification
REQ-035 N=4, K=3, start at cycle 0: CLEAR at cycle 1 with arr_clr=1; rd_en high cycles 2-4 with rd_k=0,1,2; FLUSH cycles 5-12; done=1 at cycle 13; res_valid=1 from cycle 14.
REQ-036 In that job, rd_a lane 0=0x11 and lane 3=0x44 for rd_k=0: row_out lane 0=0x11 at cycle 4 and lane 3=0x44 at cycle 7; both lanes are zero before and after the valid window.
REQ-037 K=0: arr_clr pulses at cycle 1 and done=1 at cycle 2; rd_en is never asserted.
REQ-038 A start pulse during FEED produces no change to rd_k sequencing or done timing; exactly one done pulse is produced.
REQ-039 rst asserted during FLUSH, then released: all outputs are 0 at once; a following start with K=2 gives the normal timing of REQ-021 to REQ-023.
REQ-040 Back-to-back jobs, with start in the cycle after done: res_valid drops on the accepting edge and the second job's arr_clr precedes its first rd_en by 1 cycle.
